// File: rtl/mbist_axi_slave.sv
// rtl/mbist_axi_slave.sv - AXI word-array responder closing the loop with the MBIST AXI master
module mbist_axi_slave #(
    parameter int ADDR_BITS  = 26,
    parameter int DATA_BITS  = 16,
    parameter int MEM_AW     = 12,
    parameter int RD_LATENCY = 2
) (
    input  logic                 core_clk,
    input  logic                 core_rst_sync,
    input  logic                 awvalid,
    output logic                 awready,
    input  logic [ADDR_BITS-1:0] awaddr,
    input  logic [7:0]           awlen,
    input  logic                 wvalid,
    output logic                 wready,
    input  logic                 wlast,
    input  logic [DATA_BITS-1:0] wdata,
    output logic                 bvalid,
    input  logic                 bready,
    input  logic                 arvalid,
    output logic                 arready,
    input  logic [ADDR_BITS-1:0] araddr,
    input  logic [7:0]           arlen,
    output logic                 rvalid,
    input  logic                 rready,
    output logic                 rlast,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 proto_err,
    output logic [31:0]          wr_beats,
    output logic [31:0]          rd_beats
);
    localparam int LSB   = $clog2(DATA_BITS / 8);
    localparam int WORDS = 1 << MEM_AW;

    typedef enum logic [2:0] {IDLE, WDATA, WRESP, RWAIT, RDATA} state_t;

    state_t               state;
    logic [MEM_AW-1:0]    idx;
    logic [7:0]           cnt;
    logic [7:0]           len;
    logic [3:0]           lat;
    logic [DATA_BITS-1:0] mem [WORDS];
    logic [WORDS-1:0]     valid;
    logic                 aw_fire;
    logic                 ar_fire;
    logic                 wr_fire;
    logic                 unused_addr_bits;

    // Handshake readies are masked by reset so nothing is accepted while it is held.
    assign awready = (state == IDLE) && !core_rst_sync;
    assign arready = (state == IDLE) && !awvalid && !core_rst_sync;
    assign wready  = (state == WDATA);
    assign bvalid  = (state == WRESP);
    assign rvalid  = (state == RDATA);
    assign rlast   = rvalid && (cnt == len);
    assign rdata   = (rvalid && valid[idx]) ? mem[idx] : '0;

    assign aw_fire = awvalid && awready;
    assign ar_fire = arvalid && arready;
    assign wr_fire = wvalid && wready;

    assign unused_addr_bits = ^{awaddr, araddr};

    always_ff @(posedge core_clk or posedge core_rst_sync) begin
        if (core_rst_sync) begin
            state     <= IDLE;
            idx       <= '0;
            cnt       <= '0;
            len       <= '0;
            lat       <= '0;
            valid     <= '0;
            proto_err <= 1'b0;
            wr_beats  <= '0;
            rd_beats  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (aw_fire) begin
                        idx   <= awaddr[MEM_AW+LSB-1:LSB];
                        cnt   <= '0;
                        len   <= awlen;
                        state <= WDATA;
                    end else if (ar_fire) begin
                        idx   <= araddr[MEM_AW+LSB-1:LSB];
                        cnt   <= '0;
                        len   <= arlen;
                        lat   <= 4'(RD_LATENCY);
                        state <= (RD_LATENCY == 0) ? RDATA : RWAIT;
                    end
                end
                WDATA: begin
                    if (wvalid) begin
                        valid[idx] <= 1'b1;
                        idx        <= idx + 1'b1;
                        cnt        <= cnt + 8'd1;
                        wr_beats   <= wr_beats + 32'd1;
                        // The burst length alone ends the burst; wlast is only audited.
                        if (wlast != (cnt == len))
                            proto_err <= 1'b1;
                        if (cnt == len)
                            state <= WRESP;
                    end
                end
                WRESP: begin
                    if (bready)
                        state <= IDLE;
                end
                RWAIT: begin
                    lat <= lat - 4'd1;
                    if (lat <= 4'd1)
                        state <= RDATA;
                end
                RDATA: begin
                    if (rready) begin
                        idx      <= idx + 1'b1;
                        cnt      <= cnt + 8'd1;
                        rd_beats <= rd_beats + 32'd1;
                        if (cnt == len)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge core_clk) begin
        if (wr_fire)
            mem[idx] <= wdata;
    end
endmodule

// File: tb/tb_mbist_axi_slave.sv
// tb/tb_mbist_axi_slave.sv - self-checking bench for mbist_axi_slave against a word-array model
module tb_mbist_axi_slave;
    localparam int ADDR_BITS  = 26;
    localparam int DATA_BITS  = 16;
    localparam int MEM_AW     = 12;
    localparam int RD_LATENCY = 2;
    localparam int BYTES      = DATA_BITS / 8;
    localparam int LSB        = $clog2(BYTES);
    localparam int MEM_WORDS  = 1 << MEM_AW;

    logic                 core_clk = 1'b0;
    logic                 core_rst_sync = 1'b1;
    logic                 awvalid = 1'b0, awready;
    logic [ADDR_BITS-1:0] awaddr = '0;
    logic [7:0]           awlen = '0;
    logic                 wvalid = 1'b0, wready, wlast = 1'b0;
    logic [DATA_BITS-1:0] wdata = '0;
    logic                 bvalid, bready = 1'b0;
    logic                 arvalid = 1'b0, arready;
    logic [ADDR_BITS-1:0] araddr = '0;
    logic [7:0]           arlen = '0;
    logic                 rvalid, rready = 1'b0, rlast;
    logic [DATA_BITS-1:0] rdata;
    logic                 proto_err;
    logic [31:0]          wr_beats, rd_beats;

    int tests_run = 0;
    int tests_failed = 0;

    logic [DATA_BITS-1:0] m_mem [MEM_WORDS];
    bit                   m_valid [MEM_WORDS];
    int unsigned          m_wr, m_rd;
    bit                   m_perr;
    logic [DATA_BITS-1:0] wbuf [256];

    mbist_axi_slave #(
        .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .MEM_AW(MEM_AW), .RD_LATENCY(RD_LATENCY)
    ) dut (
        .core_clk(core_clk), .core_rst_sync(core_rst_sync),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata),
        .bvalid(bvalid), .bready(bready),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rlast(rlast), .rdata(rdata),
        .proto_err(proto_err), .wr_beats(wr_beats), .rd_beats(rd_beats)
    );

    always #5 core_clk = ~core_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    function automatic int word_of(input logic [ADDR_BITS-1:0] a);
        return int'((longint'(a) / BYTES) % MEM_WORDS);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < MEM_WORDS; i++) m_valid[i] = 1'b0;
        m_wr = 0;
        m_rd = 0;
        m_perr = 1'b0;
    endtask

    // Write burst of len+1 beats from wbuf; wlast driven on beat wlast_pos; bready withheld bstall cycles.
    task automatic do_write(input logic [ADDR_BITS-1:0] addr, input int len, input int wlast_pos, input int bstall);
        int idx;
        awvalid = 1'b1; awaddr = addr; awlen = 8'(len);
        #1;
        tests_run++; if (awready !== 1'b1) begin tests_failed++; $display("FAIL wr_awready got=%b want=1", awready); end
        if (arvalid) begin
            tests_run++; if (arready !== 1'b0) begin tests_failed++; $display("FAIL wr_arready_collide got=%b want=0", arready); end
        end
        tick();
        awvalid = 1'b0;
        idx = word_of(addr);
        for (int b = 0; b <= len; b++) begin
            wvalid = 1'b1; wdata = wbuf[b]; wlast = (b == wlast_pos);
            #1;
            tests_run++; if (wready !== 1'b1 || bvalid !== 1'b0) begin tests_failed++; $display("FAIL wr_beat%0d wready=%b bvalid=%b want 1/0", b, wready, bvalid); end
            if (arvalid) begin
                tests_run++; if (arready !== 1'b0) begin tests_failed++; $display("FAIL wr_arready_busy got=%b want=0", arready); end
            end
            m_mem[idx] = wbuf[b];
            m_valid[idx] = 1'b1;
            idx = (idx + 1) % MEM_WORDS;
            m_wr++;
            if ((b == wlast_pos) != (b == len)) m_perr = 1'b1;
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        bready = 1'b0;
        for (int s = 0; s < bstall; s++) begin
            #1;
            tests_run++; if (bvalid !== 1'b1) begin tests_failed++; $display("FAIL wr_bvalid_hold cycle=%0d got=%b want=1", s, bvalid); end
            tick();
        end
        bready = 1'b1;
        #1;
        tests_run++; if (bvalid !== 1'b1) begin tests_failed++; $display("FAIL wr_bvalid got=%b want=1", bvalid); end
        tick();
        bready = 1'b0;
        tests_run++; if (bvalid !== 1'b0 || awready !== 1'b1) begin tests_failed++; $display("FAIL wr_done bvalid=%b awready=%b want 0/1", bvalid, awready); end
        tests_run++; if (wr_beats !== m_wr) begin tests_failed++; $display("FAIL wr_beats got=%0d want=%0d", wr_beats, m_wr); end
        tests_run++; if (proto_err !== m_perr) begin tests_failed++; $display("FAIL wr_proto_err got=%b want=%b", proto_err, m_perr); end
    endtask

    // Read burst; mode 0: rready=1, mode 1: rready pattern 1,0,0,1, mode 2: random rready.
    task automatic do_read(input logic [ADDR_BITS-1:0] addr, input int len, input int mode);
        int idx, lat, beat, cyc;
        logic rr;
        logic [DATA_BITS-1:0] exp;
        arvalid = 1'b1; araddr = addr; arlen = 8'(len);
        #1;
        tests_run++; if (arready !== 1'b1) begin tests_failed++; $display("FAIL rd_arready got=%b want=1", arready); end
        tick();
        arvalid = 1'b0;
        lat = 0;
        while (rvalid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        tests_run++; if (lat != RD_LATENCY) begin tests_failed++; $display("FAIL rd_latency got=%0d want=%0d", lat, RD_LATENCY); end
        idx = word_of(addr);
        beat = 0;
        cyc = 0;
        while (beat <= len && cyc < 64 * (len + 1)) begin
            case (mode)
                0: rr = 1'b1;
                1: rr = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rr = 1'($urandom_range(0, 1));
            endcase
            rready = rr;
            #1;
            exp = m_valid[idx] ? m_mem[idx] : '0;
            tests_run++;
            if (rvalid !== 1'b1 || rdata !== exp || rlast !== (beat == len)) begin
                tests_failed++;
                $display("FAIL rd_beat%0d rvalid=%b rdata=%h rlast=%b want 1/%h/%b", beat, rvalid, rdata, rlast, exp, beat == len);
            end
            tick();
            if (rr) begin
                beat++;
                idx = (idx + 1) % MEM_WORDS;
                m_rd++;
            end
            cyc++;
        end
        rready = 1'b0;
        tests_run++; if (beat != len + 1) begin tests_failed++; $display("FAIL rd_timeout beats=%0d want=%0d", beat, len + 1); end
        tests_run++; if (rvalid !== 1'b0 || rd_beats !== m_rd) begin tests_failed++; $display("FAIL rd_done rvalid=%b rd_beats=%0d want 0/%0d", rvalid, rd_beats, m_rd); end
    endtask

    task automatic test_reset();
        core_rst_sync = 1'b1;
        repeat (3) @(posedge core_clk);
        #1;
        tests_run++; if (awready !== 1'b0 || arready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready awready=%b arready=%b want 0/0", awready, arready); end
        tests_run++; if ({wready, bvalid, rvalid, rlast, proto_err} !== 5'b0) begin tests_failed++; $display("FAIL reset_flags got=%b want=00000", {wready, bvalid, rvalid, rlast, proto_err}); end
        tests_run++; if (rdata !== '0 || wr_beats !== 0 || rd_beats !== 0) begin tests_failed++; $display("FAIL reset_data rdata=%h wr=%0d rd=%0d want 0", rdata, wr_beats, rd_beats); end
        core_rst_sync = 1'b0;
        #1;
        tests_run++; if (awready !== 1'b1 || arready !== 1'b1) begin tests_failed++; $display("FAIL reset_release awready=%b arready=%b want 1/1", awready, arready); end
        model_reset();
        tick();
    endtask

    task automatic test_write_burst();
        for (int i = 0; i < 8; i++) wbuf[i] = DATA_BITS'(i * BYTES);
        do_write('0, 7, 7, 0);
    endtask

    task automatic test_read_burst();
        do_read('0, 7, 0);
    endtask

    task automatic test_read_unwritten();
        do_read(ADDR_BITS'(32'h100), 0, 0);
    endtask

    task automatic test_stall();
        for (int i = 0; i < 8; i++) wbuf[i] = DATA_BITS'($urandom);
        do_write(ADDR_BITS'(32'h400), 7, 7, 5);
        do_read(ADDR_BITS'(32'h400), 7, 1);
    endtask

    task automatic test_collision_proto();
        for (int i = 0; i < 8; i++) wbuf[i] = DATA_BITS'($urandom);
        arvalid = 1'b1; araddr = ADDR_BITS'(32'h40); arlen = 8'd7;
        do_write(ADDR_BITS'(32'h40), 7, 2, 0);
        do_read(ADDR_BITS'(32'h40), 7, 0);
        tests_run++; if (proto_err !== 1'b1) begin tests_failed++; $display("FAIL proto_err_sticky got=%b want=1", proto_err); end
    endtask

    task automatic test_wrap();
        wbuf[0] = DATA_BITS'($urandom);
        wbuf[1] = DATA_BITS'($urandom);
        do_write(ADDR_BITS'((MEM_WORDS - 1) * BYTES), 1, 1, 0);
        do_read(ADDR_BITS'((MEM_WORDS - 1) * BYTES), 1, 0);
        do_read('0, 0, 0);
    endtask

    task automatic test_reset_mid_read();
        int waitc;
        for (int i = 0; i < 8; i++) wbuf[i] = DATA_BITS'($urandom);
        do_write(ADDR_BITS'(32'h300), 7, 7, 0);
        arvalid = 1'b1; araddr = ADDR_BITS'(32'h300); arlen = 8'd7;
        tick();
        arvalid = 1'b0;
        waitc = 0;
        while (rvalid !== 1'b1 && waitc < 40) begin
            tick();
            waitc++;
        end
        rready = 1'b1;
        repeat (3) tick();
        rready = 1'b0;
        #2;
        core_rst_sync = 1'b1;
        #1;
        tests_run++; if (rvalid !== 1'b0 || rlast !== 1'b0 || rdata !== '0) begin tests_failed++; $display("FAIL midrst_outputs rvalid=%b rlast=%b rdata=%h want 0", rvalid, rlast, rdata); end
        tests_run++; if (awready !== 1'b0) begin tests_failed++; $display("FAIL midrst_awready got=%b want=0", awready); end
        tick();
        tick();
        core_rst_sync = 1'b0;
        #1;
        model_reset();
        tests_run++; if (awready !== 1'b1 || proto_err !== 1'b0) begin tests_failed++; $display("FAIL midrst_release awready=%b proto_err=%b want 1/0", awready, proto_err); end
        tests_run++; if (wr_beats !== 0 || rd_beats !== 0) begin tests_failed++; $display("FAIL midrst_counters wr=%0d rd=%0d want 0/0", wr_beats, rd_beats); end
        tick();
        do_read(ADDR_BITS'(32'h300), 7, 0);
    endtask

    task automatic test_random();
        logic [ADDR_BITS-1:0] a;
        int len;
        for (int n = 0; n < 30; n++) begin
            a = ADDR_BITS'($urandom);
            a[MEM_AW+LSB-1:0] = '0;
            a = a | ADDR_BITS'($urandom_range(0, 31) * BYTES + $urandom_range(0, BYTES - 1));
            len = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= len; i++) wbuf[i] = DATA_BITS'($urandom);
                do_write(a, len, len, $urandom_range(0, 3));
            end else begin
                do_read(a, len, 2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_read_unwritten();
        test_stall();
        test_collision_proto();
        test_wrap();
        test_reset_mid_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/mbist_axi_slave.md
# mbist_axi_slave

Testbench AXI responder that closes the loop with the MBIST AXI master: accepts write bursts into an internal word array and returns the stored data on read bursts, using the same reduced AXI channel set (no IDs, no strobes, INCR bursts only). It stands in for the DDR controller AXI front end so MBIST pass/fail can be checked without the PHY and DRAM model. It also flags burst protocol violations for the verification engineer.

## Interface
- ADDR_BITS, 26, AXI byte address width.
- DATA_BITS, 16, AXI data width; power of two, ≥8. LSB = log2(DATA_BITS/8).
- MEM_AW, 12, word-array depth is 2^MEM_AW words.
- RD_LATENCY, 2, cycles from AR handshake to first rvalid; 0..15.
- core_clk  in  1  single clock, rising edge.
- core_rst_sync  in  1  reset, asynchronous assert, active-high.
- awvalid / awready  in / out  1  write-address handshake.
- awaddr  in  ADDR_BITS  burst start byte address.
- awlen  in  8  beats minus one.
- wvalid / wready / wlast  in / out / in  1  write-data handshake and last marker.
- wdata  in  DATA_BITS  write beat.
- bvalid / bready  out / in  1  write response.
- arvalid / arready  in / out  1  read-address handshake.
- araddr  in  ADDR_BITS; arlen  in  8  read burst start/length.
- rvalid / rready / rlast  out / in / out  1  read-data handshake and last marker.
- rdata  out  DATA_BITS  read beat.
- proto_err  out  1  sticky wlast violation flag.
- wr_beats, rd_beats  out  32 each  accepted beat counters.

## Operation
- States: IDLE, WDATA, WRESP, RWAIT, RDATA. One transaction outstanding at a time.
- IDLE: awready=1; arready=~awvalid (write wins on simultaneous request). AW handshake latches word index = awaddr[MEM_AW+LSB-1:LSB], beat cnt=0, len=awlen → WDATA. AR handshake latches equivalent read index/len, latency counter=RD_LATENCY → RWAIT (RDATA directly if RD_LATENCY=0).
- WDATA: wready=1. Each wvalid beat: mem[idx]<=wdata, valid[idx]<=1, idx+1 mod 2^MEM_AW, cnt+1, wr_beats+1. Beat with cnt==len → WRESP. Burst ends on beat count only.
- proto_err set if wlast=1 on a beat with cnt<len, or wlast=0 on beat cnt==len. Cleared only by reset.
- WRESP: bvalid=1, held until bready; then → IDLE.
- RWAIT: count down; at 1 → RDATA.
- RDATA: rvalid=1; rdata = valid[idx] ? mem[idx] : 0; rlast=(cnt==len). On rvalid&rready: idx+1 mod 2^MEM_AW, cnt+1, rd_beats+1; final beat → IDLE. rdata/rlast held stable while rready=0.
- Address bits above MEM_AW+LSB ignored (aliasing); bits below LSB ignored.
- Counters wrap at 2^32.

## Timing
- Reset (async): state IDLE, all ready/valid outputs 0 while reset asserted (awready/arready gated by reset), rlast=0, rdata=0, proto_err=0, counters 0, valid[] cleared. Memory contents not cleared but unreadable (valid=0 → reads 0).
- Reset mid-burst: remaining beats of that burst are discarded; post-reset the block is in IDLE with awready=1 on the first cycle after deassertion.
- Write burst of N beats with wvalid held: AW cycle t, beats t+1..t+N, bvalid at t+N+1.
- Read burst: AR at t, first rvalid at t+1+RD_LATENCY (t+1 if 0), back-to-back beats with rready=1.
- Write then read of same word: data visible on any read whose AR handshake follows the write's final W beat.
- Outputs (valid/ready/rlast/rdata) are functions of registered state only; no input-to-output combinational path except arready from awvalid.

## Test plan
- Write 8 beats at 0x0, data = address (0,2,…,0xE, DATA_BITS=16) with wlast on beat 8, bready=1 → bvalid one cycle after beat 8, proto_err=0, wr_beats=8.
- Read back 8 beats at 0x0, RD_LATENCY=2, rready=1 → first rvalid 3 cycles after AR, rdata 0,2,…,0xE, rlast only on beat 8, rd_beats=8.
- Read unwritten address 0x100, arlen=0 → single beat rdata=0, rlast=1.
- Toggle rready 1,0,0,1 mid-burst and hold bready=0 for 5 cycles → rdata/rlast stable while stalled, bvalid held 5 cycles, no beats lost.
- awvalid and arvalid asserted same cycle in IDLE → awready=1, arready=0, write completes first; wlast on beat 3 of 8 → proto_err=1 and stays 1.
- Write at word 2^MEM_AW−1 with awlen=1 → second beat lands in word 0; assert reset during a later 8-beat read → rvalid=0 immediately, IDLE after release, proto_err=0.
